crc32_8_rx_check: RTL
=====================

# crc32_8_rx_check

Receive-side frame checker for the byte-wide CRC-32 path, polynomial 0x04C11DB7, shift-left, data bit 7 first, init 0xFFFFFFFF, no reflection, no final XOR. It accepts a byte stream in which every frame ends with a 4-byte FCS sent most-significant byte first. It forwards only the payload bytes downstream with the FCS stripped, and reports a per-frame CRC verdict, payload length and short-frame error. It sits between the byte deserializer and the frame consumer, opposite the transmit-side FCS appender.

## Interface
- INIT, 32'hFFFFFFFF, CRC register value at reset and at the start of each frame.
- LEN_W, 16, width of the payload length counter.
- clk_i  input  1  clock; all logic is rising-edge.
- rst_n_i  input  1  reset; asynchronous and active-low.
- in_valid_i  input  1  input byte valid.
- in_ready_o  output  1  input byte accepted when in_valid_i and in_ready_o are both 1.
- in_data_i  input  8  input byte.
- in_last_i  input  1  marks the final byte of a frame (the FCS LSB).
- out_valid_o  output  1  payload byte valid.
- out_ready_i  input  1  downstream ready.
- out_data_o  output  8  payload byte.
- out_last_o  output  1  marks the final payload byte of a frame.
- done_o  output  1  one-cycle pulse at end of frame.
- crc_ok_o  output  1  residue check passed; held until the next done_o.
- short_o  output  1  frame had fewer than 5 bytes; held until the next done_o.
- frame_len_o  output  LEN_W  payload byte count (total bytes − 4), saturating; held until the next done_o.

## Operation
- Reset values:
  - crc register = INIT; fill = 0; delay line = 0.
  - out_valid_o = 0, out_data_o = 0, out_last_o = 0.
  - done_o = 0, crc_ok_o = 0, short_o = 0, frame_len_o = 0.
  - in_ready_o = 1.
- in_ready_o = !out_valid_o || out_ready_i (combinational; single output register with no skid).
- On every accepted byte: crc <= crc32 byte update (crc, in_data_i), using the same equations as the team's crc32_8 core.
- Delay line: a 4-byte shift register plus a fill counter, forming states FILL (fill 0..3) and STREAM (fill = 4).
  - FILL, byte accepted, not last: shift the byte in; fill++. Nothing is output.
  - STREAM, byte accepted: the oldest byte moves to the output register (out_valid_o <= 1, out_last_o <= in_last_i); the new byte shifts in; the payload counter increments, saturating at 2^LEN_W − 1.
- End of frame (accepted byte with in_last_i = 1):
  - Next-cycle status updates: crc_ok_o <= (updated crc == 0) && (total ≥ 5); short_o <= (total < 5); frame_len_o <= payload count including this cycle's byte (0 when short); done_o pulses.
  - The crc register returns to INIT, fill to 0 and the payload counter to 0, all in the same edge.
- Short frame (1–4 bytes): no bytes are output and out_last_o never asserts; the delay line is discarded; crc_ok_o = 0.
- Frames of 5 or more bytes produce exactly one out_last_o, on the final payload byte.
- The output register holds out_data_o and out_last_o stable while out_valid_o = 1 and out_ready_i = 0. out_valid_o clears on handshake unless a new byte is loaded in the same cycle.
- Back-to-back frames: the first byte of the next frame may be accepted in the cycle immediately after the last byte. The new frame starts from INIT and fill 0.
- Asserting rst_n_i mid-frame discards all partial state. No done_o pulse is generated for the aborted frame.

## Timing
- Payload byte k appears on out_data_o on the cycle after input byte k+4 is accepted.
- The final payload byte, done_o and the updated status all appear on the same cycle, one cycle after the last byte is accepted.
- Sustained throughput is 1 byte/cycle while out_ready_i = 1.
- With out_ready_i = 0 and out_valid_o = 1, in_ready_o = 0. No input byte is accepted and no state changes.
- The residue compare uses the combinational next-crc value (one XOR tree plus a 32-bit zero compare) and is registered. There is no extra pipeline stage.

## Test plan
- Frame 31 32 33 34 35 36 37 38 39 03 76 E6 E7, out_ready_i = 1 -> output 31..39 with out_last_o on 39; done_o one cycle after E7 is accepted; crc_ok_o = 1, short_o = 0, frame_len_o = 9.
- Same frame with E6 changed to E7 -> payload 31..39 still forwarded; crc_ok_o = 0, frame_len_o = 9.
- 4-byte frame 03 76 E6 E7 -> no out_valid_o; done_o pulse with short_o = 1, crc_ok_o = 0, frame_len_o = 0. Then the 13-byte good frame back-to-back -> crc_ok_o = 1 and short_o clears.
- Good frame with out_ready_i toggled randomly (including held low for 5 cycles) -> identical payload order with no drops or duplicates; out_data_o stable while stalled; in_ready_o low while stalled.
- Two good frames back-to-back with no idle cycle -> two done_o pulses, both with crc_ok_o = 1, out_last_o on each 39, frame_len_o = 9 each.
- rst_n_i asserted after 6 bytes of a frame, then released, then the good frame sent -> all outputs at reset values during reset; the next frame passes with crc_ok_o = 1 and no residual bytes.

Source files
------------

// File: rtl/crc32_8_rx_check.sv
// Receive-side CRC-32 frame checker: strips the trailing 4-byte FCS, forwards the
// payload and reports the residue verdict, payload length and short-frame flag.
module crc32_8_rx_check #(
  parameter logic [31:0] INIT  = 32'hFFFFFFFF,
  parameter int          LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [7:0]       in_data_i,
  input  logic             in_last_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [7:0]       out_data_o,
  output logic             out_last_o,
  output logic             done_o,
  output logic             crc_ok_o,
  output logic             short_o,
  output logic [LEN_W-1:0] frame_len_o
);

  // Handshake: a byte moves on a port in a cycle where its valid and ready are both 1;
  // valid with its data/last stays stable until that handshake happens.

  localparam logic [2:0] FILL_FULL = 3'd4;

  logic [31:0]      crc_q;
  logic [31:0]      crc_next;
  logic [2:0]       fill_q;
  logic [2:0]       fill_d;
  logic [31:0]      dly_q;
  logic [LEN_W-1:0] pay_cnt_q;
  logic [LEN_W-1:0] pay_cnt_inc;
  logic             accept;
  logic             streaming;
  logic             load_out;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ 32'h04C11DB7;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  assign in_ready_o  = !out_valid_o || out_ready_i;
  assign accept      = in_valid_i && in_ready_o;
  assign crc_next    = crc32_byte(crc_q, in_data_i);
  assign pay_cnt_inc = (&pay_cnt_q) ? pay_cnt_q : pay_cnt_q + 1'b1;

  // Fill counter doubles as the FILL (0..3) / STREAM (4) state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) fill_q <= 3'd0;
    else          fill_q <= fill_d;
  end

  always_comb begin
    fill_d = fill_q;
    if (accept) begin
      if (in_last_i)               fill_d = 3'd0;
      else if (fill_q != FILL_FULL) fill_d = fill_q + 3'd1;
    end
  end

  always_comb begin
    streaming = (fill_q == FILL_FULL);
    load_out  = accept && streaming;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      crc_q     <= INIT;
      dly_q     <= '0;
      pay_cnt_q <= '0;
    end else if (accept) begin
      crc_q <= in_last_i ? INIT : crc_next;
      dly_q <= {dly_q[23:0], in_data_i};
      if (in_last_i)      pay_cnt_q <= '0;
      else if (streaming) pay_cnt_q <= pay_cnt_inc;
    end
  end

  // Oldest delay-line byte is the one that has already been followed by four bytes.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid_o <= 1'b0;
      out_data_o  <= 8'd0;
      out_last_o  <= 1'b0;
    end else if (load_out) begin
      out_valid_o <= 1'b1;
      out_data_o  <= dly_q[31:24];
      out_last_o  <= in_last_i;
    end else if (out_ready_i) begin
      out_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      done_o      <= 1'b0;
      crc_ok_o    <= 1'b0;
      short_o     <= 1'b0;
      frame_len_o <= '0;
    end else begin
      done_o <= accept && in_last_i;
      if (accept && in_last_i) begin
        crc_ok_o    <= streaming && (crc_next == 32'd0);
        short_o     <= !streaming;
        frame_len_o <= streaming ? pay_cnt_inc : '0;
      end
    end
  end

endmodule
